// File: rtl/vga_sync_to_count.sv
`timescale 1ns / 1ps
// vga_sync_to_count
// Recovers column/row counters from a pair of active-high sync inputs
// (high during active columns / active rows), re-aligns the syncs with the
// counts, and tracks whether the incoming timing matches
// TOTAL_COLS x TOTAL_ROWS through a SEARCH -> VERIFY -> LOCKED state machine.
// A free-running flywheel keeps the counters wrapping when syncs go missing.
//
// Optional build macro:
//   VGA_SYNC_ERR_CNT_EN - adds o_Err_Count, an 8-bit saturating count of
//                         timing mismatches. Without it the port is absent.
module vga_sync_to_count #(
  parameter int TOTAL_COLS = 800,
  parameter int TOTAL_ROWS = 525
) (
  input  logic       CLK,
  input  logic       i_Rst_L,
  input  logic       i_HSync,
  input  logic       i_VSync,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Frame_Start,
  output logic       o_Locked
`ifdef VGA_SYNC_ERR_CNT_EN
  ,
  output logic [7:0] o_Err_Count
`endif
);

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(TOTAL_COLS - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(TOTAL_ROWS - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Sync pipeline: stage 1 is the registered input, stage 2 its older copy.
  logic hs_s1_q, hs_s2_q;
  logic vs_s1_q, vs_s2_q;
  logic hs_rise, vs_rise;

  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] row_inc;
  logic             col_at_last, row_at_last;
  logic             frame_start_q;
  logic             mismatch;

  state_e state_q, state_d;

  // Register both syncs once, then keep one older copy for edge detection.
  always_ff @(posedge CLK or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hs_s1_q <= 1'b0;
      hs_s2_q <= 1'b0;
      vs_s1_q <= 1'b0;
      vs_s2_q <= 1'b0;
    end else begin
      // NOTE: non-blocking, so stage 2 takes stage 1's pre-edge value;
      // blocking assignments here would collapse the two stages into one.
      hs_s1_q <= i_HSync;
      hs_s2_q <= hs_s1_q;
      vs_s1_q <= i_VSync;
      vs_s2_q <= vs_s1_q;
    end
  end

  // An edge is visible while stage 1 is high and stage 2 still low; the
  // counters act on it in the same cycle stage 2 starts showing the high.
  assign hs_rise = hs_s1_q & ~hs_s2_q;
  assign vs_rise = vs_s1_q & ~vs_s2_q;

  assign col_at_last = (col_q == COL_LAST);
  assign row_at_last = (row_q == ROW_LAST);
  assign row_inc     = row_at_last ? '0 : row_q + 10'd1;

  // Next counts and mismatch: VSync edge wins over HSync edge, which wins
  // over the flywheel; a mismatch is any line/frame boundary out of place.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal -- no latches.
    col_d    = col_q + 10'd1;
    row_d    = row_q;
    mismatch = 1'b0;
    if (vs_rise) begin
      col_d    = '0;
      row_d    = '0;
      mismatch = ~(col_at_last & row_at_last);
    end else if (hs_rise) begin
      col_d    = '0;
      row_d    = row_inc;
      mismatch = ~col_at_last;
    end else if (col_at_last) begin
      col_d    = '0;
      row_d    = row_inc;
      mismatch = 1'b1;
    end
  end

  // Count registers and the frame-start pulse; identical in every FSM state.
  always_ff @(posedge CLK or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      col_q         <= '0;
      row_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      frame_start_q <= vs_rise;
    end
  end

  // Lock FSM: state register.
  always_ff @(posedge CLK or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= ST_SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Lock FSM: next state. Any frame edge starts verification; a clean one
  // while verifying locks; any mismatch outside SEARCH drops back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEARCH: begin
        if (vs_rise) state_d = ST_VERIFY;
      end
      ST_VERIFY: begin
        if (mismatch)     state_d = ST_SEARCH;
        else if (vs_rise) state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (mismatch) state_d = ST_SEARCH;
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // Lock FSM: output decode.
  always_comb begin
    o_Locked = (state_q == ST_LOCKED);
  end

  assign o_HSync       = hs_s2_q;
  assign o_VSync       = vs_s2_q;
  assign o_Col_Count   = col_q;
  assign o_Row_Count   = row_q;
  assign o_Frame_Start = frame_start_q;

`ifdef VGA_SYNC_ERR_CNT_EN
  logic [7:0] err_q, err_d;

  // Mismatch counter next value, holding at 255 once saturated.
  always_comb begin
    err_d = err_q;
    if (mismatch && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  // Mismatch counter register.
  always_ff @(posedge CLK or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      err_q <= 8'd0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_Err_Count = err_q;
`endif

endmodule

// File: tb/tb_vga_sync_to_count.sv
`timescale 1ns / 1ps
// Self-checking bench for vga_sync_to_count on a scaled-down raster
// (100 clocks/line, 25 lines/frame, sync high for col<80 / row<20) so full
// frames stay short. A timing-rule reference model is compared every cycle,
// and scenario monitors check lock, flywheel and reset behaviour.
module tb_vga_sync_to_count;

  localparam int TC      = 100;
  localparam int TR      = 25;
  localparam int ACT_C   = 80;
  localparam int ACT_R   = 20;
  localparam int RST_ROW = 9;
  localparam int RST_COL = 30;

  logic       CLK     = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_HSync = 1'b0;
  logic       i_VSync = 1'b0;
  logic       o_HSync, o_VSync, o_Frame_Start, o_Locked;
  logic [9:0] o_Col_Count, o_Row_Count;
`ifdef VGA_SYNC_ERR_CNT_EN
  logic [7:0] o_Err_Count;
`endif

  vga_sync_to_count #(
    .TOTAL_COLS(TC),
    .TOTAL_ROWS(TR)
  ) dut (
    .CLK          (CLK),
    .i_Rst_L      (i_Rst_L),
    .i_HSync      (i_HSync),
    .i_VSync      (i_VSync),
    .o_HSync      (o_HSync),
    .o_VSync      (o_VSync),
    .o_Col_Count  (o_Col_Count),
    .o_Row_Count  (o_Row_Count),
    .o_Frame_Start(o_Frame_Start),
    .o_Locked     (o_Locked)
`ifdef VGA_SYNC_ERR_CNT_EN
    ,
    .o_Err_Count  (o_Err_Count)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] outs();
    return {o_HSync, o_VSync, o_Frame_Start, o_Locked, o_Col_Count, o_Row_Count};
  endfunction

  // ---------------- reference model ----------------
  // Works on the input history: the outputs after clock k reflect the input
  // seen one clock earlier, and a boundary is a 0->1 step in that history.
  bit m_hs_hist[2];   // [0] = input two clocks back, [1] = one clock back
  bit m_vs_hist[2];
  int m_col, m_row, m_err;
  int m_good_edges;   // 0: searching, 1: one frame edge seen, 2: locked
  bit m_hs_o, m_vs_o, m_fs;

  task automatic model_reset();
    m_hs_hist = '{0, 0};
    m_vs_hist = '{0, 0};
    m_col = 0; m_row = 0; m_err = 0; m_good_edges = 0;
    m_hs_o = 0; m_vs_o = 0; m_fs = 0;
  endtask

  task automatic model_step(input bit hs_now, input bit vs_now);
    bit hs_rise, vs_rise, line_end, frame_end, bad;
    hs_rise   = m_hs_hist[1] && !m_hs_hist[0];
    vs_rise   = m_vs_hist[1] && !m_vs_hist[0];
    line_end  = (m_col == TC - 1);
    frame_end = line_end && (m_row == TR - 1);
    if (vs_rise)      bad = !frame_end;
    else if (hs_rise) bad = !line_end;
    else              bad = line_end;
    if (vs_rise)  m_good_edges = bad ? ((m_good_edges == 0) ? 1 : 0)
                                     : ((m_good_edges >= 1) ? 2 : 1);
    else if (bad) m_good_edges = 0;
    if (vs_rise) begin
      m_col = 0; m_row = 0;
    end else if (hs_rise || line_end) begin
      m_col = 0; m_row = (m_row + 1) % TR;
    end else begin
      m_col = m_col + 1;
    end
    if (bad && m_err < 255) m_err++;
    m_fs   = vs_rise;
    m_hs_o = m_hs_hist[1];
    m_vs_o = m_vs_hist[1];
    m_hs_hist = '{m_hs_hist[1], hs_now};
    m_vs_hist = '{m_vs_hist[1], vs_now};
  endtask

  // ---------------- scenario monitor state ----------------
  int prev_col = 0, prev_row = 0;
  bit prev_hs_o = 0, prev_vs_o = 0, prev_lock = 0;
  int fs_seen = 0;
  int lock_from = -1;   // expected lock from this frame start on; -1 = off
  bit mon_std = 0;      // standard raster running: check last active row
  int fly_wraps = 0;
  int unlock_events = 0;

  task automatic clear_prev();
    prev_col = 0; prev_row = 0;
    prev_hs_o = 0; prev_vs_o = 0; prev_lock = 0;
  endtask

  task automatic monitor();
    bit hs_rise_o, vs_rise_o;
    hs_rise_o = o_HSync && !prev_hs_o;
    vs_rise_o = o_VSync && !prev_vs_o;
    if (hs_rise_o || vs_rise_o) begin
      check("line_start_col", o_Col_Count, 0);
      if (prev_col != TC - 1 || (vs_rise_o && prev_row != TR - 1))
        check("mismatch_unlock", o_Locked, 0);
    end else if (prev_col == TC - 1) begin
      fly_wraps++;
      check("flywheel_wrap_col", o_Col_Count, 0);
      check("flywheel_unlock", o_Locked, 0);
    end
    if (vs_rise_o) begin
      check("frame_start_pulse", o_Frame_Start, 1);
      check("frame_start_row", o_Row_Count, 0);
    end
    if (o_Frame_Start) begin
      fs_seen++;
      if (lock_from >= 0) check("lock_at_frame_start", o_Locked, (fs_seen >= lock_from));
    end
    if (mon_std && fs_seen >= 1 && prev_vs_o && !o_VSync)
      check("last_active_row", prev_row, ACT_R - 1);
    if (prev_lock && !o_Locked) unlock_events++;
    prev_col  = o_Col_Count;
    prev_row  = o_Row_Count;
    prev_hs_o = o_HSync;
    prev_vs_o = o_VSync;
    prev_lock = o_Locked;
  endtask

  // One pixel clock: drive inputs at the falling edge, let the rising edge
  // happen, then compare at the next falling edge.
  task automatic cycle(input bit hs, input bit vs);
    i_HSync = hs;
    i_VSync = vs;
    @(negedge CLK);
    model_step(hs, vs);
    check("model_outputs", outs(),
          {m_hs_o, m_vs_o, m_fs, (m_good_edges == 2), 10'(m_col), 10'(m_row)});
`ifdef VGA_SYNC_ERR_CNT_EN
    check("model_err_count", o_Err_Count, m_err);
`endif
    monitor();
  endtask

  task automatic run_line(input int row, input int c_from, input int c_to, input bit hs_en);
    for (int c = c_from; c < c_to; c++) cycle(hs_en && (c < ACT_C), row < ACT_R);
  endtask

  task automatic run_frame(input int short_row, input int fly_from, input int fly_to);
    for (int r = 0; r < TR; r++)
      run_line(r, 0, (r == short_row) ? TC - 1 : TC, !(r >= fly_from && r < fly_to));
  endtask

  // Entered at a falling edge; asserts reset between clock edges so the
  // first check proves the clear does not wait for CLK.
  task automatic apply_reset(input int hold);
    #2 i_Rst_L = 1'b0;
    #1 check("async_reset_outputs", outs(), 0);
`ifdef VGA_SYNC_ERR_CNT_EN
    check("async_reset_err", o_Err_Count, 0);
`endif
    repeat (hold) @(negedge CLK);
    check("reset_hold_outputs", outs(), 0);
    i_Rst_L = 1'b1;
    model_reset();
    clear_prev();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int short_row, fly_from, wraps0, unl0, fs0;
    bit rh, rv;
`ifdef VGA_SYNC_ERR_CNT_EN
    logic [7:0] err_before;
`endif
    model_reset();
    @(negedge CLK);
    apply_reset(3);

    // Standard raster for three frames: lock from the second frame start.
    fs_seen = 0; lock_from = 2; mon_std = 1;
    repeat (3) run_frame(-1, -1, -1);
    check("locked_after_3_frames", o_Locked, 1);

    // One line shortened by a clock while locked.
    short_row = $urandom_range(2, TR - 3);
    fs_seen = 0; lock_from = 0; unl0 = unlock_events;
`ifdef VGA_SYNC_ERR_CNT_EN
    err_before = o_Err_Count;
`endif
    run_frame(short_row, -1, -1);
    check("short_line_unlocked", o_Locked, 0);
    check("short_line_unlock_events", unlock_events - unl0, 1);
`ifdef VGA_SYNC_ERR_CNT_EN
    check("short_line_err_delta", 32'(o_Err_Count - err_before), 1);
`endif
    fs_seen = 0; lock_from = 2;
    repeat (3) run_frame(-1, -1, -1);
    check("short_line_relocked", o_Locked, 1);

    // HSync missing for three lines: flywheel wraps at TC-1 and unlocks.
    fly_from = $urandom_range(2, 8);
    fs_seen = 0; lock_from = 0; wraps0 = fly_wraps;
    run_frame(-1, fly_from, fly_from + 3);
    check("flywheel_wrap_count", fly_wraps - wraps0, 3);
    check("flywheel_unlocked", o_Locked, 0);
    fs_seen = 0; lock_from = 2;
    repeat (3) run_frame(-1, -1, -1);
    check("flywheel_relocked", o_Locked, 1);

    // Reset pulse mid-frame, then relock on two clean frame edges.
    fs_seen = 0; lock_from = 0;
    for (int r = 0; r < RST_ROW; r++) run_line(r, 0, TC, 1'b1);
    run_line(RST_ROW, 0, RST_COL, 1'b1);
    apply_reset(3);
    mon_std = 0; lock_from = -1;
    run_line(RST_ROW, RST_COL, TC, 1'b1);
    for (int r = RST_ROW + 1; r < TR; r++) run_line(r, 0, TC, 1'b1);
    fs_seen = 0; lock_from = 2; mon_std = 1;
    repeat (2) run_frame(-1, -1, -1);
    check("reset_relocked", o_Locked, 1);

    // Both syncs rising together mid-frame: treated as a frame edge.
    mon_std = 0; lock_from = -1;
    for (int r = 0; r < 10; r++) run_line(r, 0, TC, 1'b1);
    repeat (6) cycle(1'b0, 1'b0);
    fs0 = fs_seen;
    repeat (10) cycle(1'b1, 1'b1);
    check("simultaneous_frame_start", fs_seen - fs0, 1);

    // Random sync activity against the model.
    rh = 1'b0; rv = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)  rh = ~rh;
      if ($urandom_range(0, 31) == 0) rv = ~rv;
      cycle(rh, rv);
    end
    repeat (3) run_frame(-1, -1, -1);
    check("random_then_relocked", o_Locked, 1);

    // 300 mismatching HSync edges after a fresh reset.
    apply_reset(2);
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0); cycle(1'b0, 1'b0);
    end
    check("many_mismatch_unlocked", o_Locked, 0);
`ifdef VGA_SYNC_ERR_CNT_EN
    check("err_count_saturated", o_Err_Count, 255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_to_count.md
VGA_SYNC_TO_COUNT -- requirements
Module: vga_sync_to_count

Interface
REQ-001 The block SHALL have parameter TOTAL_COLS, default 800, meaning pixel clocks per line.
REQ-002 The block SHALL have parameter TOTAL_ROWS, default 525, meaning lines per frame.
REQ-003 The block SHALL have port CLK, input, 1, the pixel clock; all logic is on its rising edge.
REQ-004 The block SHALL have port i_Rst_L, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port i_HSync, input, 1, line sync, high during active columns.
REQ-006 The block SHALL have port i_VSync, input, 1, frame sync, high during active rows.
REQ-007 The block SHALL have port o_HSync, output, 1, i_HSync delayed to align with counts.
REQ-008 The block SHALL have port o_VSync, output, 1, i_VSync delayed to align with counts.
REQ-009 The block SHALL have port o_Col_Count, output, 10, recovered column.
REQ-010 The block SHALL have port o_Row_Count, output, 10, recovered row.
REQ-011 The block SHALL have port o_Frame_Start, output, 1, one-cycle pulse at row 0 / col 0.
REQ-012 The block SHALL have port o_Locked, output, 1, high while sync timing matches parameters.

Function
REQ-013 The block SHALL register both sync inputs once, and SHALL detect rising edges from the registered copies.
REQ-014 o_HSync/o_VSync SHALL equal the inputs delayed exactly 2 CLK cycles, and the counts SHALL share this alignment.
REQ-015 On a VSync rising edge, both counts SHALL be 0 and o_Frame_Start SHALL be 1 in the same cycle o_VSync first shows high.
REQ-016 On an HSync rising edge without a VSync edge, col SHALL become 0 and row SHALL increment, wrapping TOTAL_ROWS-1 to 0.
REQ-017 Otherwise col SHALL increment, and at TOTAL_COLS-1 it SHALL wrap to 0 with row incrementing (flywheel).
REQ-018 Simultaneous HSync and VSync edges SHALL be treated as a VSync edge, so the VSync edge has priority.
REQ-019 Count behaviour SHALL be identical in all FSM states; only o_Locked depends on state.
REQ-020 A mismatch SHALL be defined as either (a) an HSync edge while col != TOTAL_COLS-1, or (b) a flywheel wrap with no HSync edge.
REQ-021 A mismatch SHALL additionally include (c) a VSync edge while row != TOTAL_ROWS-1 or col != TOTAL_COLS-1.
REQ-022 The FSM SHALL have states SEARCH, VERIFY and LOCKED.
REQ-023 In SEARCH, a VSync edge SHALL move the FSM to VERIFY.
REQ-024 In VERIFY, a mismatch SHALL move the FSM to SEARCH, and a clean VSync edge SHALL move it to LOCKED.
REQ-025 In LOCKED, a mismatch SHALL move the FSM to SEARCH, and a mismatch on a VSync edge SHALL still realign the counts.
REQ-026 o_Locked SHALL be high only in LOCKED, rising in the o_Frame_Start cycle of the second good frame edge and falling in the cycle the mismatch is applied.

Reset
REQ-027 While i_Rst_L=0, all outputs, counts, pipeline registers and the error counter SHALL be 0 immediately, and the FSM SHALL be in SEARCH.
REQ-028 After release, the block SHALL need 2 consecutive clean frame edges before o_Locked asserts.

Configuration
REQ-029 The block SHALL support macro VGA_SYNC_ERR_CNT_EN: when defined, it adds output o_Err_Count (8-bit, resets to 0) counting mismatches, saturating at 255.
REQ-030 Without VGA_SYNC_ERR_CNT_EN, the o_Err_Count port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-031 The bench SHALL check: a standard 800x525 source (sync high while col<640 / row<480) for 3 frames -> o_Locked=1 from the second frame start, col 0 at each o_HSync rise, and row 479 on the last o_VSync-high line.
REQ-032 The bench SHALL check: while locked, one line shortened to 799 clocks -> o_Locked=0 at that HSync edge, relock after 2 clean frame edges, and o_Err_Count=1.
REQ-033 The bench SHALL check: i_HSync held 0 while locked -> flywheel wrap at col 799, o_Locked=0, and counts keep wrapping 0..799.
REQ-034 The bench SHALL check: i_Rst_L pulsed low at row 200, col 300 -> all outputs 0 asynchronously, followed by a relock sequence per REQ-028.
REQ-035 The bench SHALL check: HSync and VSync rising together -> o_Frame_Start=1, row=0, col=0, and row does not increment.
REQ-036 The bench SHALL check: with VGA_SYNC_ERR_CNT_EN, 300 mismatches -> o_Err_Count=255; without the macro, the build has no o_Err_Count port.
